serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial unsigned/two's-complement subtractor: computes a - b one bit per clock, LSB first,
//  through a single full-subtractor cell (difference + borrow) and a borrow flip-flop.
//  Companion to the full-adder datapath cells; intended as the area-cheap arithmetic unit for
//  multi-cycle datapaths. Operands enter via a valid/ready handshake; the result leaves via a second one.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range >= 2
// PORTS
//  clk           in   1      single clock; all state updates on rising edge
//  rst           in   1      synchronous reset, active-high
//  start_valid   in   1      operands a, b valid this cycle
//  start_ready   out  1      block can accept operands (high only in IDLE)
//  a             in   WIDTH  minuend
//  b             in   WIDTH  subtrahend
//  result_valid  out  1      diff/borrow_out/overflow valid (high only in DONE)
//  result_ready  in   1      consumer accepts result
//  diff          out  WIDTH  a - b modulo 2^WIDTH
//  borrow_out    out  1      final borrow; 1 iff a < b unsigned
//  overflow      out  1      signed overflow: (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB])
//  busy          out  1      high in BUSY
// BEHAVIOUR
//  - Reset: state=IDLE, start_ready=1, result_valid=0, busy=0, diff=0, borrow_out=0, overflow=0,
//    shift regs, borrow FF and bit counter cleared. rst wins over every other input on the same edge.
//  - FSM states IDLE, BUSY, DONE:
//    IDLE: start_ready=1. On edge with start_valid=1: capture a->sa, b->sb, borrow FF=0, count=0,
//          latch a[MSB], b[MSB] for overflow, go BUSY. start_valid=0: stay IDLE.
//    BUSY: each edge: d = sa[0]^sb[0]^br; br' = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br);
//          shift d into diff from MSB side (diff <= {d, diff[WIDTH-1:1]}); sa, sb shift right; count++.
//          Edge where count == WIDTH-1 processes last bit and goes DONE.
//          start_valid ignored (start_ready=0); result_ready ignored.
//    DONE: result_valid=1; diff, borrow_out(=final br), overflow held stable.
//          On edge with result_ready=1: go IDLE, result_valid drops next cycle. Otherwise hold indefinitely.
//  - Latency: result_valid first high exactly WIDTH rising edges after the accepting edge; throughput one
//    op per WIDTH+2 cycles with result_ready tied high (accept, WIDTH bit cycles, DONE, IDLE).
//  - No accept in DONE even if result_ready=1 same cycle; next start accepted earliest in IDLE.
//  - diff/borrow_out/overflow only meaningful when result_valid=1; they change freely in BUSY.
//  - Operands must not be assumed held by upstream after the accepting edge; block uses only captured copies.
//  - Reset mid-BUSY or mid-DONE: aborts op, pending result discarded, reset values next cycle.
//  - Arithmetic is mod 2^WIDTH; borrow_out and overflow are independent flags, both may be 1.
// TESTING (WIDTH=8, result_ready=1 unless stated)
//  1. a=0x05,b=0x03 -> diff=0x02,borrow_out=0,overflow=0; result_valid exactly 8 edges after accept.
//  2. a=0x03,b=0x05 -> diff=0xFE,borrow_out=1,overflow=0.
//  3. a=0x80,b=0x01 -> diff=0x7F,borrow_out=0,overflow=1; a=0x7F,b=0xFF -> diff=0x80,borrow_out=1,overflow=1.
//  4. a=0x00,b=0x00 with start_valid held high through BUSY and result_ready low 5 cycles in DONE ->
//     only one accept, diff=0x00 held 5+ cycles, start_ready=0 throughout, IDLE after result_ready.
//  5. accept 0x55-0x22, assert rst on 3rd BUSY cycle -> next cycle all outputs at reset values, IDLE;
//     then 0xFF-0xFF -> diff=0x00,borrow_out=0,overflow=0.
//  6. Random 1000 ops with random start_valid/result_ready stalls vs. reference model (a-b)&0xFF,
//     a<b, signed overflow; check no lost or duplicated results.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b LSB-first through one full-subtractor
// cell and a borrow flop, with valid/ready handshakes on operands and result.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             d_bit;
  logic             br_next;

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    diff_d  = diff_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    d_bit   = sa_q[0] ^ sb_q[0] ^ br_q;
    br_next = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);

    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // Each difference bit enters at the MSB, so after WIDTH shifts bit 0 is at diff[0].
        diff_d = {d_bit, diff_q[WIDTH-1:1]};
        sa_d   = sa_q >> 1;
        sb_d   = sb_q >> 1;
        br_d   = br_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (result_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
    end
  end

  assign start_ready  = (state_q == S_IDLE);
  assign result_valid = (state_q == S_DONE);
  assign busy         = (state_q == S_BUSY);
  assign diff         = diff_q;
  assign borrow_out   = br_q;
  // Operand sign bits are latched at accept since upstream may drop a/b afterwards.
  assign overflow     = (a_msb_q ^ b_msb_q) & (a_msb_q ^ diff_q[WIDTH-1]);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of serial_subtractor at WIDTH=8 against
// hand-computed vectors and a small arithmetic reference model.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       result_valid;
  logic       result_ready;
  logic [7:0] diff;
  logic       borrow_out;
  logic       overflow;
  logic       busy;

  int n_cmp;
  int n_fail;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .diff         (diff),
    .borrow_out   (borrow_out),
    .overflow     (overflow),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts one operation from IDLE, waits (bounded) for the result, then returns the block to IDLE.
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib,
                       output logic [7:0] od, output logic ob, output logic oo,
                       output int lat);
    a = ia;
    b = ib;
    start_valid  = 1'b1;
    result_ready = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    a = ~ia;
    b = ~ib;
    lat = 0;
    while (result_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    od = diff;
    ob = borrow_out;
    oo = overflow;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_valid = 1'b0;
    result_ready = 1'b1;
    a = 8'h00;
    b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({start_ready, result_valid, busy, diff, borrow_out, overflow} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b busy=%b diff=%h br=%b ov=%b, want 1 0 0 00 0 0",
               start_ready, result_valid, busy, diff, borrow_out, overflow);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic [7:0] ed [4];
    logic       eb [4];
    logic       eo [4];
    logic [7:0] od;
    logic       ob, oo;
    int         lat;
    va = '{8'h05, 8'h03, 8'h80, 8'h7F};
    vb = '{8'h03, 8'h05, 8'h01, 8'hFF};
    ed = '{8'h02, 8'hFE, 8'h7F, 8'h80};
    eb = '{1'b0, 1'b1, 1'b0, 1'b1};
    eo = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], od, ob, oo, lat);
      n_cmp++;
      if (lat !== 8) begin
        n_fail++;
        $display("FAIL latency_%0d: got %0d edges, want 8", i, lat);
      end
      n_cmp++;
      if ({od, ob, oo} !== {ed[i], eb[i], eo[i]}) begin
        n_fail++;
        $display("FAIL basic_%0d %h-%h: got diff=%h br=%b ov=%b, want diff=%h br=%b ov=%b",
                 i, va[i], vb[i], od, ob, oo, ed[i], eb[i], eo[i]);
      end
      n_cmp++;
      if (start_ready !== 1'b1 || result_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_after_%0d: got rdy=%b vld=%b, want 1 0", i, start_ready, result_valid);
      end
    end
  endtask

  task automatic test_stall();
    int bad_rdy;
    int bad_hold;
    a = 8'h00;
    b = 8'h00;
    start_valid  = 1'b1;
    result_ready = 1'b0;
    @(posedge clk); #1;
    bad_rdy = 0;
    for (int i = 0; i < 8; i++) begin
      if (start_ready !== 1'b0 || busy !== 1'b1) bad_rdy++;
      @(posedge clk); #1;
    end
    bad_hold = 0;
    for (int i = 0; i < 6; i++) begin
      if (start_ready !== 1'b0 || result_valid !== 1'b1 || diff !== 8'h00 ||
          borrow_out !== 1'b0 || overflow !== 1'b0) bad_hold++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bad_rdy !== 0) begin
      n_fail++;
      $display("FAIL stall_busy: got %0d bad BUSY cycles, want 0", bad_rdy);
    end
    n_cmp++;
    if (bad_hold !== 0) begin
      n_fail++;
      $display("FAIL stall_done_hold: got %0d bad DONE cycles, want 0", bad_hold);
    end
    start_valid  = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (start_ready !== 1'b1 || result_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: got rdy=%b vld=%b busy=%b, want 1 0 0", start_ready, result_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] od;
    logic       ob, oo;
    int         lat;
    a = 8'h55;
    b = 8'h22;
    start_valid  = 1'b1;
    result_ready = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: got busy=%b, want 1", busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({start_ready, result_valid, busy, diff, borrow_out, overflow} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset: got rdy=%b vld=%b busy=%b diff=%h br=%b ov=%b, want 1 0 0 00 0 0",
               start_ready, result_valid, busy, diff, borrow_out, overflow);
    end
    rst = 1'b0;
    do_op(8'hFF, 8'hFF, od, ob, oo, lat);
    n_cmp++;
    if ({od, ob, oo} !== {8'h00, 1'b0, 1'b0} || lat !== 8) begin
      n_fail++;
      $display("FAIL after_reset FF-FF: got diff=%h br=%b ov=%b lat=%0d, want 00 0 0 lat=8", od, ob, oo, lat);
    end
  endtask

  task automatic test_random();
    logic [7:0] qa [$];
    logic [7:0] qb [$];
    logic [7:0] ea, eb, ed;
    logic       ebr, eov;
    int         pops, cyc, bad;
    pops = 0;
    cyc  = 0;
    bad  = 0;
    while (pops < 1000 && cyc < 60000) begin
      @(posedge clk); #1;
      start_valid  = ($urandom_range(0, 9) < 7);
      result_ready = ($urandom_range(0, 9) < 6);
      a = 8'($urandom);
      b = 8'($urandom);
      @(negedge clk);
      if (start_valid && start_ready) begin
        if (qa.size() != 0) bad++;
        qa.push_back(a);
        qb.push_back(b);
      end
      if (result_valid && result_ready) begin
        n_cmp++;
        if (qa.size() == 0) begin
          n_fail++;
          $display("FAIL rand_dup: got result diff=%h with no pending op, want none", diff);
        end else begin
          ea  = qa.pop_front();
          eb  = qb.pop_front();
          ed  = ea - eb;
          ebr = (ea < eb);
          eov = (ea[7] ^ eb[7]) & (ea[7] ^ ed[7]);
          if ({diff, borrow_out, overflow} !== {ed, ebr, eov}) begin
            n_fail++;
            $display("FAIL rand_%0d %h-%h: got diff=%h br=%b ov=%b, want diff=%h br=%b ov=%b",
                     pops, ea, eb, diff, borrow_out, overflow, ed, ebr, eov);
          end
        end
        pops++;
      end
      cyc++;
    end
    start_valid  = 1'b0;
    result_ready = 1'b1;
    n_cmp++;
    if (pops !== 1000) begin
      n_fail++;
      $display("FAIL rand_count: got %0d results in %0d cycles, want 1000", pops, cyc);
    end
    n_cmp++;
    if (qa.size() !== 0 || bad !== 0) begin
      n_fail++;
      $display("FAIL rand_lost: got %0d pending and %0d overlapping accepts, want 0 and 0", qa.size(), bad);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
